// File: rtl/spio_hss_multiplexer_chan_sched_pkg.sv
// spio_hss_multiplexer_chan_sched_pkg: shared sizes, scheduler states and channel-wrap helper.
package spio_hss_multiplexer_chan_sched_pkg;
  localparam int NUM_CHANS = 8;
  localparam int CRED_MAX = 8;
  localparam int CLR_BITS = 1;
  localparam int CHAN_BITS = $clog2(NUM_CHANS);
  localparam int CRED_BITS = $clog2(CRED_MAX + 1);
  typedef enum logic [1:0] {SCHED_IDLE_ST, SCHED_ARB_ST, SCHED_BUSY_ST} sched_st_e;
  function automatic logic [CHAN_BITS-1:0] next_chan(input logic [CHAN_BITS-1:0] c);
    return (c == CHAN_BITS'(NUM_CHANS - 1)) ? '0 : c + 1'b1;
  endfunction
endpackage

// File: rtl/spio_hss_multiplexer_chan_sched_if.sv
// spio_hss_multiplexer_chan_sched_if: scheduler bus; to_err exists only with SPIO_HSS_SCHED_TIMEOUT_EN.
interface spio_hss_multiplexer_chan_sched_if;
  import spio_hss_multiplexer_chan_sched_pkg::*;
  logic [NUM_CHANS-1:0] chan_req;
  logic [NUM_CHANS-1:0] stop_rem;
  logic [NUM_CHANS-1:0] gnt;
  logic gnt_vld;
  logic [CHAN_BITS-1:0] gnt_chan;
  logic frm_done;
  logic cred_ret;
  logic [CRED_BITS-1:0] cred_ret_cnt;
  logic [CLR_BITS-1:0] cur_colour;
  logic [CLR_BITS-1:0] ooc_colour;
  logic ooc_vld;
  logic [CRED_BITS-1:0] cred_cnt;
`ifdef SPIO_HSS_SCHED_TIMEOUT_EN
  logic to_err;
`endif
  modport master (
    output chan_req, stop_rem, frm_done, cred_ret, cred_ret_cnt, cur_colour,
    input gnt, gnt_vld, gnt_chan, ooc_colour, ooc_vld, cred_cnt
`ifdef SPIO_HSS_SCHED_TIMEOUT_EN
    , input to_err
`endif
  );
  modport slave (
    input chan_req, stop_rem, frm_done, cred_ret, cred_ret_cnt, cur_colour,
    output gnt, gnt_vld, gnt_chan, ooc_colour, ooc_vld, cred_cnt
`ifdef SPIO_HSS_SCHED_TIMEOUT_EN
    , output to_err
`endif
  );
endinterface

// File: rtl/spio_hss_multiplexer_chan_sched_rr_arb.sv
// spio_hss_multiplexer_chan_sched_rr_arb: first eligible channel at or after rr_ptr, wrapping.
module spio_hss_multiplexer_chan_sched_rr_arb
  import spio_hss_multiplexer_chan_sched_pkg::*;
(
  input  logic [NUM_CHANS-1:0] eligible,
  input  logic [CHAN_BITS-1:0] rr_ptr,
  output logic [NUM_CHANS-1:0] win_oh,
  output logic [CHAN_BITS-1:0] win_idx,
  output logic                 found
);
  logic [CHAN_BITS-1:0] j;
  always_comb begin
    j = '0;
    win_idx = '0;
    for (int i = NUM_CHANS - 1; i >= 0; i--) begin
      j = CHAN_BITS'((int'(rr_ptr) + i) % NUM_CHANS);
      win_idx = eligible[j] ? j : win_idx;
    end
    found = |eligible;
    win_oh = found ? NUM_CHANS'(1) << win_idx : '0;
  end
endmodule

// File: rtl/spio_hss_multiplexer_chan_sched.sv
// spio_hss_multiplexer_chan_sched: round-robin frame-slot scheduler with credit limit and out-of-credit pulse.
// Optional grant timeout under SPIO_HSS_SCHED_TIMEOUT_EN.
module spio_hss_multiplexer_chan_sched
`ifdef SPIO_HSS_SCHED_TIMEOUT_EN
  #(parameter int TO_CYCLES = 1024)
`endif
(
  input logic clk,
  input logic rst,
  spio_hss_multiplexer_chan_sched_if.slave bus
);
  import spio_hss_multiplexer_chan_sched_pkg::*;
  sched_st_e st;
  logic [CHAN_BITS-1:0] rr_ptr;
  logic [NUM_CHANS-1:0] elig;
  logic [NUM_CHANS-1:0] win_oh;
  logic [CHAN_BITS-1:0] win_idx;
  logic found, dec, to_fire, ooc_fire, armed;
  logic [CRED_BITS:0] sum;
  logic [CRED_BITS-1:0] cred_nxt;
  assign elig = bus.chan_req & ~bus.stop_rem;
  spio_hss_multiplexer_chan_sched_rr_arb u_arb (
    .eligible(elig), .rr_ptr(rr_ptr), .win_oh(win_oh), .win_idx(win_idx), .found(found)
  );
`ifdef SPIO_HSS_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  assign to_fire = st == SCHED_BUSY_ST && !bus.frm_done && to_cnt == TO_W'(TO_CYCLES - 1);
  always_ff @(posedge clk) begin
    to_cnt <= (rst || st != SCHED_BUSY_ST) ? '0 : to_cnt + 1'b1;
    bus.to_err <= !rst && to_fire;
  end
`else
  assign to_fire = 1'b0;
`endif
  // A colour change re-arms the out-of-credit request even while still starved.
  always_comb begin
    dec = st == SCHED_ARB_ST && found;
    ooc_fire = st == SCHED_IDLE_ST && bus.cred_cnt == '0 && |elig && (armed || bus.cur_colour != bus.ooc_colour);
    sum = (CRED_BITS+1)'(bus.cred_cnt) + (bus.cred_ret ? (CRED_BITS+1)'(bus.cred_ret_cnt) : '0)
        + (CRED_BITS+1)'(to_fire) - (CRED_BITS+1)'(dec);
    cred_nxt = sum > (CRED_BITS+1)'(CRED_MAX) ? CRED_BITS'(CRED_MAX) : sum[CRED_BITS-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= SCHED_IDLE_ST;
      rr_ptr <= '0;
      armed <= 1'b1;
      bus.gnt <= '0;
      bus.gnt_vld <= 1'b0;
      bus.gnt_chan <= '0;
      bus.ooc_vld <= 1'b0;
      bus.ooc_colour <= '0;
      bus.cred_cnt <= CRED_BITS'(CRED_MAX);
    end else begin
      bus.cred_cnt <= cred_nxt;
      bus.ooc_vld <= ooc_fire;
      bus.ooc_colour <= ooc_fire ? bus.cur_colour : bus.ooc_colour;
      armed <= bus.cred_cnt != '0 ? 1'b1 : ooc_fire ? 1'b0 : armed;
      case (st)
        SCHED_IDLE_ST: st <= (|elig && bus.cred_cnt != '0) ? SCHED_ARB_ST : SCHED_IDLE_ST;
        SCHED_ARB_ST: begin
          st <= found ? SCHED_BUSY_ST : SCHED_IDLE_ST;
          bus.gnt <= win_oh;
          bus.gnt_vld <= found;
          bus.gnt_chan <= found ? win_idx : bus.gnt_chan;
        end
        SCHED_BUSY_ST:
          if (bus.frm_done || to_fire) begin
            st <= SCHED_IDLE_ST;
            bus.gnt <= '0;
            bus.gnt_vld <= 1'b0;
            rr_ptr <= next_chan(bus.gnt_chan);
          end
        default: st <= SCHED_IDLE_ST;
      endcase
    end
  end
endmodule

// File: tb/tb_spio_hss_multiplexer_chan_sched.sv
// tb_spio_hss_multiplexer_chan_sched: directed + randomized grant/credit checks against a rule-level model.
module tb_spio_hss_multiplexer_chan_sched;
  import spio_hss_multiplexer_chan_sched_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  spio_hss_multiplexer_chan_sched_if bus();
  spio_hss_multiplexer_chan_sched dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int failed = 0;
  int m_cred, m_ptr, w, pulses;
  logic [7:0] rq, sp;
  function automatic int pick(input logic [7:0] e, input int p);
    for (int k = 0; k < 8; k++) if (e[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction
  function automatic int sat(input int x);
    return x > CRED_MAX ? CRED_MAX : x;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic give(input int cnt);
    bus.chan_req = '0;
    bus.cred_ret = 1'b1;
    bus.cred_ret_cnt = CRED_BITS'(cnt);
    tick;
    bus.cred_ret = 1'b0;
    m_cred = sat(m_cred + cnt);
    chk("cred_ret", 32'(bus.cred_cnt), 32'(m_cred));
  endtask
  // ret >= 0 returns that many credits in the ARB cycle; hold cycles scramble requests during BUSY.
  task automatic serve(input logic [7:0] req, input logic [7:0] stop, input int hold, input int ret);
    int win;
    bus.chan_req = req;
    bus.stop_rem = stop;
    win = pick(req & ~stop, m_ptr);
    tick;
    if (ret >= 0) begin
      bus.cred_ret = 1'b1;
      bus.cred_ret_cnt = CRED_BITS'(ret);
    end
    tick;
    bus.cred_ret = 1'b0;
    m_cred = sat(m_cred + (ret >= 0 ? ret : 0) - 1);
    chk("gnt_vld", 32'(bus.gnt_vld), 32'd1);
    chk("gnt", 32'(bus.gnt), 32'd1 << win);
    chk("gnt_chan", 32'(bus.gnt_chan), 32'(win));
    chk("cred_cnt", 32'(bus.cred_cnt), 32'(m_cred));
    chk("ooc_quiet", 32'(bus.ooc_vld), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bus.chan_req = 8'($urandom);
      bus.stop_rem = 8'($urandom);
      tick;
      chk("gnt_hold", 32'(bus.gnt), 32'd1 << win);
    end
    bus.frm_done = 1'b1;
    tick;
    bus.frm_done = 1'b0;
    bus.chan_req = '0;
    chk("rel_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rel_gnt", 32'(bus.gnt), 32'd0);
    m_ptr = (win + 1) % 8;
  endtask
  initial begin
    bus.chan_req = '0;
    bus.stop_rem = '0;
    bus.frm_done = 1'b0;
    bus.cred_ret = 1'b0;
    bus.cred_ret_cnt = '0;
    bus.cur_colour = '0;
    rst = 1'b1;
    tick;
    tick;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_chan", 32'(bus.gnt_chan), 32'd0);
    chk("rst_ooc", 32'(bus.ooc_vld), 32'd0);
    chk("rst_oocc", 32'(bus.ooc_colour), 32'd0);
    chk("rst_cred", 32'(bus.cred_cnt), 32'd8);
    rst = 1'b0;
    m_cred = 8;
    m_ptr = 0;
    repeat (3) serve(8'h05, 8'h00, 2, -1);
    give(3);
    repeat (3) serve(8'hFF, 8'hFE, 1, -1);
    serve(8'hFF, 8'h00, 0, -1);
    serve(8'hFF, 8'h01, 0, -1);
    for (int n = 0; n < 24; n++) begin
      if (m_cred == 0) give($urandom_range(1, 15));
      rq = 8'($urandom);
      sp = 8'($urandom & $urandom);
      if ((rq & ~sp) == 0) begin
        rq = 8'h01;
        sp = 8'h00;
      end
      serve(rq, sp, $urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1);
    end
    give(8);
    repeat (8) serve(8'hFF, 8'h00, 0, -1);
    chk("starved", 32'(bus.cred_cnt), 32'd0);
    bus.chan_req = 8'hFF;
    bus.stop_rem = '0;
    bus.cur_colour = 1'b1;
    tick;
    chk("ooc_vld", 32'(bus.ooc_vld), 32'd1);
    chk("ooc_colour", 32'(bus.ooc_colour), 32'd1);
    pulses = 0;
    repeat (5) begin
      tick;
      pulses += int'(bus.ooc_vld);
      chk("no_gnt_starved", 32'(bus.gnt_vld), 32'd0);
    end
    chk("ooc_once", 32'(pulses), 32'd0);
    bus.cur_colour = 1'b0;
    tick;
    chk("ooc_recolour", 32'(bus.ooc_vld), 32'd1);
    chk("ooc_colour0", 32'(bus.ooc_colour), 32'd0);
    tick;
    chk("ooc_drop", 32'(bus.ooc_vld), 32'd0);
    give(3);
    serve(8'hFF, 8'h00, 1, -1);
    give(4);
    chk("pre_concur", 32'(bus.cred_cnt), 32'd6);
    serve(8'h30, 8'h00, 0, 5);
    chk("concur", 32'(bus.cred_cnt), 32'd8);
    bus.chan_req = 8'h08;
    tick;
    bus.chan_req = '0;
    tick;
    chk("abort_vld", 32'(bus.gnt_vld), 32'd0);
    chk("abort_cred", 32'(bus.cred_cnt), 32'(m_cred));
    tick;
    chk("abort_idle", 32'(bus.gnt_vld), 32'd0);
    bus.chan_req = 8'h08;
    bus.stop_rem = '0;
    tick;
    tick;
    w = pick(8'h08, m_ptr);
    chk("busy_ch3", 32'(bus.gnt), 32'd1 << w);
    bus.chan_req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("mid_rst_cred", 32'(bus.cred_cnt), 32'd8);
    m_cred = 8;
    m_ptr = 0;
    serve(8'h0A, 8'h00, 1, -1);
    chk("post_rst_ptr", 32'(m_ptr), 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
